fc_argmax_collector: RTL and testbench

FC_ARGMAX_COLLECTOR -- requirements
Module: fc_argmax_collector

---
 rtl/fc_argmax_collector.sv | 131 +++++++++++++
 tb/tb_fc_argmax_collector.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fc_argmax_collector.sv
// fc_argmax_collector
//   Collects NUM_CLASSES signed scores from the FC neuron bank, one per
//   accepted handshake in index order, and reports the index of the largest
//   score. Ties keep the lower index.
//
//   Optional feature: define FC_ARGMAX_SCORE_OUT_EN to add the max_score
//   output, which holds the winning score alongside class_out.
//
// Ports
//   clk         in   single clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   one-cycle pulse; begins (or restarts) a collection
//   fc_enable   out  enable for the FC neuron bank, high only while collecting
//   score_valid in   score_in carries one neuron result this cycle
//   score_in    in   signed neuron result, presented in index order
//   score_ready out  high while collecting; accept = score_valid & score_ready
//   class_out   out  index of the winning class
//   done        out  level; class_out (and max_score) valid
//   max_score   out  winning score (only with FC_ARGMAX_SCORE_OUT_EN)
module fc_argmax_collector #(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned SCORE_W     = 38,
    parameter int unsigned IDX_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      fc_enable,
    input  logic                      score_valid,
    input  logic signed [SCORE_W-1:0] score_in,
    output logic                      score_ready,
    output logic        [IDX_W-1:0]   class_out,
    output logic                      done
`ifdef FC_ARGMAX_SCORE_OUT_EN
    ,
    output logic signed [SCORE_W-1:0] max_score
`endif
);

    localparam logic signed [SCORE_W-1:0] MIN_SCORE = {1'b1, {(SCORE_W-1){1'b0}}};
    localparam logic        [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    state_e                     state;
    logic        [IDX_W-1:0]    cnt;
    logic signed [SCORE_W-1:0]  run_max;
    logic        [IDX_W-1:0]    best_idx;

    logic better;
    logic last;

    // Strictly greater: an equal later score never displaces an earlier one.
    assign better = score_in > run_max;
    assign last   = cnt == LAST_IDX;

    // fc_enable is registered and tracks the COLLECT state exactly.
    assign score_ready = fc_enable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            cnt       <= '0;
            run_max   <= MIN_SCORE;
            best_idx  <= '0;
            fc_enable <= 1'b0;
            done      <= 1'b0;
            class_out <= '0;
`ifdef FC_ARGMAX_SCORE_OUT_EN
            max_score <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StCollect;
                        cnt       <= '0;
                        run_max   <= MIN_SCORE;
                        best_idx  <= '0;
                        fc_enable <= 1'b1;
                    end
                end
                StCollect: begin
                    // start wins over a coincident score: the score is dropped.
                    if (start) begin
                        cnt      <= '0;
                        run_max  <= MIN_SCORE;
                        best_idx <= '0;
                    end else if (score_valid) begin
                        if (better) begin
                            run_max  <= score_in;
                            best_idx <= cnt;
                        end
                        if (last) begin
                            // Fold the final comparison straight into the result.
                            state     <= StDone;
                            fc_enable <= 1'b0;
                            done      <= 1'b1;
                            class_out <= better ? cnt : best_idx;
`ifdef FC_ARGMAX_SCORE_OUT_EN
                            max_score <= better ? score_in : run_max;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (start) begin
                        state     <= StCollect;
                        cnt       <= '0;
                        run_max   <= MIN_SCORE;
                        best_idx  <= '0;
                        fc_enable <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    fc_enable <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fc_argmax_collector.sv
// Bench for fc_argmax_collector: table of directed score sets, abort/reset
// sequences, and randomized sets checked against an argmax reference model.
module tb_fc_argmax_collector;

    localparam int NC = 10;
    localparam int SW = 38;
    localparam int IW = 4;
    localparam int NV = 7;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic                 score_valid;
    logic signed [SW-1:0] score_in;
    logic                 fc_enable;
    logic                 score_ready;
    logic        [IW-1:0] class_out;
    logic                 done;
`ifdef FC_ARGMAX_SCORE_OUT_EN
    logic signed [SW-1:0] max_score;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fc_argmax_collector #(
        .NUM_CLASSES(NC),
        .SCORE_W    (SW),
        .IDX_W      (IW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .fc_enable  (fc_enable),
        .score_valid(score_valid),
        .score_in   (score_in),
        .score_ready(score_ready),
        .class_out  (class_out),
        .done       (done)
`ifdef FC_ARGMAX_SCORE_OUT_EN
        ,
        .max_score  (max_score)
`endif
    );

    typedef struct packed {
        logic [NC-1:0][SW-1:0] sc;
        logic [IW-1:0]         exp_cls;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input longint s [NC], input int unsigned e);
        vec_t r;
        for (int i = 0; i < NC; i++) r.sc[i] = s[i][SW-1:0];
        r.exp_cls = IW'(e);
        return r;
    endfunction

    // Reference: find the maximum value, then the first index holding it.
    function automatic int unsigned ref_argmax(input longint s [NC]);
        longint m;
        m = s[0];
        foreach (s[i]) if (s[i] > m) m = s[i];
        for (int i = 0; i < NC; i++) if (s[i] == m) return i;
        return 0;
    endfunction

    function automatic longint ref_max(input longint s [NC]);
        longint m;
        m = s[0];
        foreach (s[i]) if (s[i] > m) m = s[i];
        return m;
    endfunction

    task automatic check(input string nm, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, return 1 time unit after the posedge.
    task automatic drive_cycle(input logic st, input logic v, input logic [SW-1:0] s);
        @(negedge clk);
        start       = st;
        score_valid = v;
        score_in    = s;
        @(posedge clk);
        #1;
        start       = 1'b0;
        score_valid = 1'b0;
    endtask

    task automatic run_set(input string nm, input longint s [NC], input int unsigned exp_cls,
                           input bit coin_valid, input int unsigned max_gap);
        logic [SW-1:0] big;
        bit            early;
        early = 1'b0;
        big   = {1'b0, {(SW-1){1'b1}}};
        // A coincident score would win if it were accepted.
        drive_cycle(1'b1, coin_valid, big);
        check({nm, "/start_fc_enable"}, fc_enable, 1);
        check({nm, "/start_done"}, done, 0);
        for (int i = 0; i < NC; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                drive_cycle(1'b0, 1'b0, '0);
                if (done !== 1'b0) early = 1'b1;
            end
            drive_cycle(1'b0, 1'b1, s[i][SW-1:0]);
            if (i < NC - 1 && done !== 1'b0) early = 1'b1;
        end
        check({nm, "/early_done"}, early, 0);
        check({nm, "/done"}, done, 1);
        check({nm, "/class_out"}, class_out, exp_cls);
        check({nm, "/fc_enable_off"}, fc_enable, 0);
        check({nm, "/score_ready_off"}, score_ready, 0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
        check({nm, "/max_score"}, max_score, ref_max(s));
`endif
        // Scores offered in DONE must be ignored.
        drive_cycle(1'b0, 1'b1, big);
        drive_cycle(1'b0, 1'b0, '0);
        check({nm, "/hold_done"}, done, 1);
        check({nm, "/hold_class"}, class_out, exp_cls);
    endtask

    initial begin
        longint tmp [NC];
        longint s   [NC];
        longint v;
        int     mode;

        tmp = '{5, -3, 100, 7, 0, 1, 2, 3, 4, 99};
        vecs[0] = mk(tmp, 2);
        foreach (tmp[i]) tmp[i] = -(longint'(1) <<< 37);
        vecs[1] = mk(tmp, 0);
        tmp = '{1, 2, 3, 9, 0, -5, 8, 9, 4, -1};
        vecs[2] = mk(tmp, 3);
        tmp = '{0, 1, 2, 3, 4, 5, 50, 6, 7, 8};
        vecs[3] = mk(tmp, 6);
        tmp = '{-7, -6, -5, -4, -3, -2, -1, -1, -1, 0};
        vecs[4] = mk(tmp, 9);
        tmp = '{-1, -5, -9, -2, -3, -4, -6, -7, -8, -10};
        vecs[5] = mk(tmp, 0);
        tmp = '{3, 3, 3, 3, 3, 0, 3, 3, 3, 3};
        tmp[5] = (longint'(1) <<< 37) - 1;
        vecs[6] = mk(tmp, 5);

        rst = 1'b1; start = 1'b0; score_valid = 1'b0; score_in = '0;
        #1;
        check("reset/fc_enable", fc_enable, 0);
        check("reset/score_ready", score_ready, 0);
        check("reset/done", done, 0);
        check("reset/class_out", class_out, 0);
`ifdef FC_ARGMAX_SCORE_OUT_EN
        check("reset/max_score", max_score, 0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // score_valid in IDLE changes nothing.
        repeat (3) drive_cycle(1'b0, 1'b1, 38'd77);
        check("idle/fc_enable", fc_enable, 0);
        check("idle/score_ready", score_ready, 0);
        check("idle/done", done, 0);

        for (int k = 0; k < NV; k++) begin
            for (int i = 0; i < NC; i++) s[i] = longint'($signed(vecs[k].sc[i]));
            run_set($sformatf("vec%0d", k), s, int'(vecs[k].exp_cls), (k % 2) == 1, 1);
        end

        // Abort after 4 accepted scores, including a large one that must be discarded.
        drive_cycle(1'b1, 1'b0, '0);
        drive_cycle(1'b0, 1'b1, 38'd1);
        drive_cycle(1'b0, 1'b1, 38'd1000);
        drive_cycle(1'b0, 1'b1, 38'd2);
        drive_cycle(1'b0, 1'b1, 38'd3);
        check("abort/done_low", done, 0);
        for (int i = 0; i < NC; i++) s[i] = longint'($signed(vecs[3].sc[i]));
        run_set("abort_restart", s, 6, 1'b0, 0);

        // Abort with start coincident with a score in COLLECT.
        drive_cycle(1'b1, 1'b0, '0);
        repeat (3) drive_cycle(1'b0, 1'b1, 38'd500);
        for (int i = 0; i < NC; i++) s[i] = longint'($signed(vecs[2].sc[i]));
        run_set("abort_coin", s, 3, 1'b1, 0);

        // Asynchronous reset in DONE clears outputs without a clock edge.
        for (int i = 0; i < NC; i++) s[i] = longint'($signed(vecs[0].sc[i]));
        run_set("pre_rst", s, 2, 1'b0, 0);
        #2 rst = 1'b1;
        #1;
        check("rst_done/class_out", class_out, 0);
        check("rst_done/done", done, 0);
        @(negedge clk);
        rst = 1'b0;

        // Asynchronous reset after 5 scores, then a clean run.
        drive_cycle(1'b1, 1'b0, '0);
        repeat (5) drive_cycle(1'b0, 1'b1, 38'd900);
        #2 rst = 1'b1;
        #1;
        check("rst_mid/fc_enable", fc_enable, 0);
        check("rst_mid/score_ready", score_ready, 0);
        check("rst_mid/done", done, 0);
        check("rst_mid/class_out", class_out, 0);
        @(negedge clk);
        rst = 1'b0;
        run_set("post_rst", s, 2, 1'b0, 0);

        for (int r = 0; r < 20; r++) begin
            mode = int'($urandom_range(0, 2));
            v = longint'($urandom_range(0, 6)) - 3;
            for (int i = 0; i < NC; i++) begin
                if (mode == 0) begin
                    s[i] = longint'($urandom_range(0, 6)) - 3;
                end else if (mode == 1) begin
                    s[i] = {$urandom(), $urandom()};
                    s[i] = (s[i] <<< (64 - SW)) >>> (64 - SW);
                end else begin
                    s[i] = v;
                end
            end
            run_set($sformatf("rand%0d", r), s, ref_argmax(s), bit'($urandom_range(0, 1)), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
